textmode_ctrl: RTL and testbench

Parametrised text-mode display controller for the RGB LCD path. Generates the horizontal and vertical timing from the pixel clock alone; no line-rate clock domain is used. Fetches a cell word from external VRAM and a glyph row from an external font ROM through a fixed-latency pipeline, and outputs a 4-bit IRGB colour index to the downstream `cga` palette. Adds three things the previous design lacked: integer pixel scaling, attribute blink, and an optional blinking underline cursor.

---
 rtl/textdisp_pkg.sv | 39 +++
 rtl/textdisp_timing.sv | 64 ++++++
 rtl/textmode_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_textmode_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/textdisp_pkg.sv
// rtl/textdisp_pkg.sv - shared constants and types for the text-mode display controller
package textdisp_pkg;

    // Cell word bit positions
    localparam int ATTR_BLINK   = 15;
    localparam int ATTR_BG_LSB  = 12;
    localparam int ATTR_FG_I    = 11;
    localparam int ATTR_FG_LSB  = 8;
    localparam int ATTR_CHR_LSB = 0;

    // Default 480x272 panel timing
    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 8;
    localparam int DEF_H_SYNC   = 4;
    localparam int DEF_H_BP     = 43;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 12;

    // Clock cycles from counter position to registered pixel
    localparam int PIPE_LAT = 5;

    // Per-pixel sideband travelling alongside the fetch pipeline
    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
        logic       vb;
        logic       cur;
        logic [2:0] gcol;
    } side_t;

    // Map an active-high raw sync onto the panel's sync polarity
    function automatic logic sync_level(input logic raw, input logic pol);
        return raw ? pol : ~pol;
    endfunction

endpackage

// File: rtl/textdisp_timing.sv
// rtl/textdisp_timing.sv - pixel/line counters with raw sync, active and frame-wrap decode
module textdisp_timing #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          active_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          vblank_o,
    output logic          frame_wrap_o
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_wrap, y_last;

    assign x_wrap = (x_q == XW'(HT - 1));
    assign y_last = (y_q == YW'(VT - 1));

    // Next pixel position: x wraps every line, y advances on the x wrap
    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_wrap) begin
            x_d = '0;
            y_d = y_last ? '0 : y_q + 1'b1;
        end
    end

    // Position register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign active_o     = (x_q < XW'(H_ACTIVE)) && (y_q < YW'(V_ACTIVE));
    assign hsync_o      = (x_q >= XW'(H_ACTIVE + H_FP)) && (x_q < XW'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_o      = (y_q >= YW'(V_ACTIVE + V_FP)) && (y_q < YW'(V_ACTIVE + V_FP + V_SYNC));
    assign vblank_o     = (x_q == '0) && (y_q == YW'(V_ACTIVE));
    assign frame_wrap_o = x_wrap && y_last;

endmodule

// File: rtl/textmode_ctrl.sv
// rtl/textmode_ctrl.sv - text-mode LCD controller top; TEXTDISP_CURSOR_EN adds the underline cursor
module textmode_ctrl
    import textdisp_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter int SCALE        = 2,
    parameter int SYNC_POL     = 0,
    parameter int BLINK_FRAMES = 16,
    localparam int COLS        = H_ACTIVE / (8 * SCALE),
    localparam int ROWS        = V_ACTIVE / (8 * SCALE),
    localparam int AW          = $clog2(COLS * ROWS)
) (
    input  logic          pxclk_i,
    input  logic          rstn_i,
    output logic [AW-1:0] vram_addr_o,
    input  logic [15:0]   vram_data_i,
    output logic [9:0]    font_addr_o,
    input  logic [7:0]    font_row_i,
`ifdef TEXTDISP_CURSOR_EN
    input  logic          cursor_en_i,
    input  logic [4:0]    cursor_row_i,
    input  logic [5:0]    cursor_col_i,
`endif
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          den_o,
    output logic [3:0]    rgbi_o,
    output logic          vblank_o
);

    localparam int   HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   XW  = $clog2(HT);
    localparam int   YW  = $clog2(VT);
    localparam int   SH  = $clog2(SCALE);
    localparam int   CSH = SH + 3;
    localparam int   FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic POL = (SYNC_POL != 0);

    if (SCALE != 1 && SCALE != 2 && SCALE != 4) begin : g_bad_scale
        $error("SCALE must be 1, 2 or 4");
    end
    if ((H_ACTIVE % (8 * SCALE)) != 0 || (V_ACTIVE % (8 * SCALE)) != 0) begin : g_bad_active
        $error("H_ACTIVE and V_ACTIVE must be multiples of 8*SCALE");
    end

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          active, hs_raw, vs_raw, vb_raw, frame_wrap;

    textdisp_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .XW(XW), .YW(YW)
    ) u_timing (
        .clk_i        (pxclk_i),
        .rstn_i       (rstn_i),
        .x_o          (x),
        .y_o          (y),
        .active_o     (active),
        .hsync_o      (hs_raw),
        .vsync_o      (vs_raw),
        .vblank_o     (vb_raw),
        .frame_wrap_o (frame_wrap)
    );

    logic [XW-1:0] cell_col;
    logic [YW-1:0] cell_row;
    logic [2:0]    grow;
    logic          cur_hit;
    logic [AW-1:0] addr_d;
    side_t         s1_d;

`ifdef TEXTDISP_CURSOR_EN
    assign cur_hit = cursor_en_i && (grow == 3'd7)
                     && (int'(cursor_row_i) == int'(cell_row))
                     && (int'(cursor_col_i) == int'(cell_col));
`else
    assign cur_hit = 1'b0;
`endif

    // Cell and glyph coordinates from the counters; SCALE is a power of two so only shifts
    always_comb begin
        cell_col    = x >> CSH;
        cell_row    = y >> CSH;
        grow        = y[SH +: 3];
        addr_d      = AW'(int'(cell_row) * COLS + int'(cell_col));
        s1_d        = '0;
        s1_d.active = active;
        s1_d.hs     = hs_raw;
        s1_d.vs     = vs_raw;
        s1_d.vb     = vb_raw;
        s1_d.cur    = cur_hit;
        s1_d.gcol   = x[SH +: 3];
    end

    side_t       s1_q, s2_q, s3_q, s4_q;
    logic [2:0]  grow1_q, grow2_q;
    logic [15:8] attr3_q, attr4_q;

    // Stages 1-2: VRAM address out, sideband waits for the cell word
    always_ff @(posedge pxclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vram_addr_o <= '0;
            s1_q        <= '0;
            grow1_q     <= '0;
            s2_q        <= '0;
            grow2_q     <= '0;
        end else begin
            vram_addr_o <= addr_d;
            s1_q        <= s1_d;
            grow1_q     <= grow;
            s2_q        <= s1_q;
            grow2_q     <= grow1_q;
        end
    end

    // Stages 3-4: font address from the cell character, attributes wait for the glyph row
    always_ff @(posedge pxclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            font_addr_o <= '0;
            attr3_q     <= '0;
            s3_q        <= '0;
            attr4_q     <= '0;
            s4_q        <= '0;
        end else begin
            font_addr_o <= {vram_data_i[ATTR_CHR_LSB +: 7], grow2_q};
            attr3_q     <= vram_data_i[15:8];
            s3_q        <= s2_q;
            attr4_q     <= attr3_q;
            s4_q        <= s3_q;
        end
    end

    logic           unused_rsvd;
    assign unused_rsvd = vram_data_i[7];

    logic [FCW-1:0] frame_cnt_q;
    logic           blink_phase_q;

    // Frame counter drives the blink half-period
    always_ff @(posedge pxclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    logic [3:0] fg, bg, pix;
    logic       pbit;

    // Colour select: glyph bit, then attribute blink, then cursor, then blanking
    always_comb begin
        fg   = attr4_q[ATTR_FG_LSB +: 4];
        bg   = {1'b0, attr4_q[ATTR_BG_LSB +: 3]};
        pbit = font_row_i[s4_q.gcol];
        pix  = pbit ? fg : bg;
        if (attr4_q[ATTR_BLINK] && blink_phase_q) pix = bg;
        if (s4_q.cur && !blink_phase_q) pix = fg;
        if (!s4_q.active) pix = 4'h0;
    end

    // Stage 5: registered pixel and LCD controls, all aligned
    always_ff @(posedge pxclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rgbi_o   <= 4'h0;
            den_o    <= 1'b0;
            hsync_o  <= ~POL;
            vsync_o  <= ~POL;
            vblank_o <= 1'b0;
        end else begin
            rgbi_o   <= pix;
            den_o    <= s4_q.active;
            hsync_o  <= sync_level(s4_q.hs, POL);
            vsync_o  <= sync_level(s4_q.vs, POL);
            vblank_o <= s4_q.vb;
        end
    end

endmodule

// File: tb/tb_textmode_ctrl.sv
// tb/tb_textmode_ctrl.sv - self-checking bench for textmode_ctrl on a reduced panel timing
module tb_textmode_ctrl;

    localparam int HA = 48, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 32, VFP = 2, VSW = 2, VBP = 2;
    localparam int SC = 2, BF = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FR = HT * VT;
    localparam int CELL = 8 * SC;
    localparam int COLS = HA / CELL;
    localparam int ROWS = VA / CELL;
    localparam int AW = $clog2(COLS * ROWS);
    localparam int CUR_ROW = 1, CUR_COL = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [AW-1:0] vram_addr_o;
    logic [15:0]   vram_q;
    logic [9:0]    font_addr_o;
    logic [7:0]    font_q;
    logic          hsync_o, vsync_o, den_o, vblank_o;
    logic [3:0]    rgbi_o;
    logic          cur_en = 1'b1;
    logic [4:0]    cur_row = 5'(CUR_ROW);
    logic [5:0]    cur_col = 6'(CUR_COL);

    logic [15:0] vram [0:(1<<AW)-1];
    logic [7:0]  font [0:1023];

    int checks = 0;
    int errors = 0;
    int k = 0;
    int den_cnt = 0, hs_cnt = 0, vb_cnt = 0;

    textmode_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SCALE(SC), .SYNC_POL(0), .BLINK_FRAMES(BF)
    ) dut (
        .pxclk_i     (clk),
        .rstn_i      (rstn),
        .vram_addr_o (vram_addr_o),
        .vram_data_i (vram_q),
        .font_addr_o (font_addr_o),
        .font_row_i  (font_q),
`ifdef TEXTDISP_CURSOR_EN
        .cursor_en_i (cur_en),
        .cursor_row_i(cur_row),
        .cursor_col_i(cur_col),
`endif
        .hsync_o     (hsync_o),
        .vsync_o     (vsync_o),
        .den_o       (den_o),
        .rgbi_o      (rgbi_o),
        .vblank_o    (vblank_o)
    );

    always #5 clk = ~clk;

    // Synchronous VRAM and font ROM: data valid one cycle after the address
    always @(posedge clk) begin
        vram_q <= vram[vram_addr_o];
        font_q <= font[font_addr_o];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_hsync"}, 32'(hsync_o), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync_o), 32'd1);
        chk({tag, "_den"}, 32'(den_o), 32'd0);
        chk({tag, "_rgbi"}, 32'(rgbi_o), 32'd0);
        chk({tag, "_vblank"}, 32'(vblank_o), 32'd0);
        chk({tag, "_vram_addr"}, 32'(vram_addr_o), 32'd0);
        chk({tag, "_font_addr"}, 32'(font_addr_o), 32'd0);
    endtask

    // Reference: pixel index j = cycles since reset release minus the pipeline latency
    task automatic check_cycle();
        int j, f, r, x, y, ph;
        logic [15:0] w;
        logic [7:0]  g;
        logic [3:0]  fg, bg, px;
        logic        act, hs, vs, vb;

        j = k - 5;
        if (j < 0) begin
            act = 1'b0; hs = 1'b1; vs = 1'b1; vb = 1'b0; px = 4'h0;
        end else begin
            f  = j / FR;
            r  = j % FR;
            y  = r / HT;
            x  = r % HT;
            act = (x < HA) && (y < VA);
            hs  = !((x >= HA + HFP) && (x < HA + HFP + HSW));
            vs  = !((y >= VA + VFP) && (y < VA + VFP + VSW));
            vb  = (x == 0) && (y == VA);
            px  = 4'h0;
            if (act) begin
                w  = vram[(y / CELL) * COLS + x / CELL];
                g  = font[int'(w[6:0]) * 8 + (y / SC) % 8];
                fg = w[11:8];
                bg = {1'b0, w[14:12]};
                ph = (f / BF) % 2;
                px = g[(x / SC) % 8] ? fg : bg;
                if (w[15] && ph == 1) px = bg;
`ifdef TEXTDISP_CURSOR_EN
                if (y / CELL == CUR_ROW && x / CELL == CUR_COL && (y / SC) % 8 == 7 && ph == 0) px = fg;
`endif
            end
            if (f == 0 && y == 0 && x == 0) chk("glyph_A_bg", 32'(rgbi_o), 32'h1);
            if (f == 0 && y == 0 && x == 4) chk("glyph_A_fg", 32'(rgbi_o), 32'hF);
            den_cnt += int'(den_o);
            hs_cnt  += int'(!hsync_o);
            vb_cnt  += int'(vblank_o);
            if (r == FR - 1) begin
                chk("frame_den_cycles", 32'(den_cnt), 32'(HA * VA));
                chk("frame_hsync_cycles", 32'(hs_cnt), 32'(VT * HSW));
                chk("frame_vblank_pulses", 32'(vb_cnt), 32'd1);
                den_cnt = 0; hs_cnt = 0; vb_cnt = 0;
            end
        end
        chk("den", 32'(den_o), 32'(act));
        chk("hsync", 32'(hsync_o), 32'(hs));
        chk("vsync", 32'(vsync_o), 32'(vs));
        chk("vblank", 32'(vblank_o), 32'(vb));
        chk("rgbi", 32'(rgbi_o), 32'(px));

        j = k - 1;
        if (j >= 0) begin
            r = j % FR; y = r / HT; x = r % HT;
            if (x < HA && y < VA) chk("vram_addr", 32'(vram_addr_o), 32'((y / CELL) * COLS + x / CELL));
        end
        j = k - 3;
        if (j >= 0) begin
            r = j % FR; y = r / HT; x = r % HT;
            if (x < HA && y < VA) begin
                w = vram[(y / CELL) * COLS + x / CELL];
                chk("font_addr", 32'(font_addr_o), 32'(int'(w[6:0]) * 8 + (y / SC) % 8));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        check_cycle();
    endtask

    initial begin
        logic [7:0] glyph_a [8];
        glyph_a = '{8'h0C, 8'h1E, 8'h33, 8'h33, 8'h3F, 8'h33, 8'h33, 8'h00};
        for (int i = 0; i < (1 << AW); i++) vram[i] = 16'($urandom);
        vram[0] = 16'h1F41;
        vram[1] = 16'h9E41;
        for (int i = 0; i < 1024; i++) font[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) font[8'h41 * 8 + i] = glyph_a[i];

        #2 rstn = 1'b0;
        #1 check_reset_values("reset_async");
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset_held");

        @(negedge clk) rstn = 1'b1;
        k = 0; den_cnt = 0; hs_cnt = 0; vb_cnt = 0;
        repeat (6 * FR + 5) step();

        while ((k % FR) != 10 * HT + 20) step();
        #2 rstn = 1'b0;
        #1 check_reset_values("reset_midline");
        @(negedge clk);
        @(negedge clk) rstn = 1'b1;
        k = 0; den_cnt = 0; hs_cnt = 0; vb_cnt = 0;
        repeat (FR + 10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
